// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter that shares the register-file write
// port between the ALU result path (req 0) and the load/immediate path (req 1).
// Owns the 2:1 data select and a one-deep registered output stage. With
// wb_ready held high it sustains one beat per cycle.
module wb_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_src,
    output logic              conflict
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_r;
    logic                last_r;
    logic [DATA_W-1:0]   data_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                src_r;
    logic                conflict_r;

    logic                can_load_s;
    logic                grant_valid_s;
    logic                grant_s;
    logic                xfer_s;

    // Output stage can take a new beat when empty or draining this cycle.
    always_comb begin
        can_load_s = (state_r == ST_EMPTY) || wb_ready;
    end

    // Round-robin grant from the current valids; last_r breaks ties.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
        case ({req1_valid, req0_valid})
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_s       = 1'b1;
            end
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_s       = ~last_r;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_s       = 1'b0;
            end
        endcase
    end

    // Readies are one-hot by construction and forced low during reset.
    always_comb begin
        req0_ready = can_load_s && grant_valid_s && !grant_s && !rst;
        req1_ready = can_load_s && grant_valid_s &&  grant_s && !rst;
        xfer_s     = req0_ready || req1_ready;
    end

    // Output-stage FSM: loads the granted beat, drains, or holds on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_EMPTY;
            last_r     <= 1'b1;
            data_r     <= {DATA_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            src_r      <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            conflict_r <= req0_valid && req1_valid && can_load_s;
            case (state_r)
                ST_EMPTY: begin
                    if (xfer_s) begin
                        state_r <= ST_FULL;
                        data_r  <= grant_s ? req1_data : req0_data;
                        addr_r  <= grant_s ? req1_addr : req0_addr;
                        src_r   <= grant_s;
                        last_r  <= grant_s;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (xfer_s) begin
                        // Drain and refill in the same cycle.
                        state_r <= ST_FULL;
                        data_r  <= grant_s ? req1_data : req0_data;
                        addr_r  <= grant_s ? req1_addr : req0_addr;
                        src_r   <= grant_s;
                        last_r  <= grant_s;
                    end else if (wb_ready) begin
                        // Payload is left in place; only the valid drops.
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        wb_valid = (state_r == ST_FULL);
        wb_data  = data_r;
        wb_addr  = addr_r;
        wb_src   = src_r;
        conflict = conflict_r;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a table of per-cycle vectors with
// hand-computed expectations, followed by a fairness run and a bounded
// wait for a grant after a stall clears.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_data;
    logic [2:0]  req0_addr;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_data;
    logic [2:0]  req1_addr;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic [2:0]  wb_addr;
    logic        wb_src;
    logic        conflict;

    int checks;
    int failures;

    wb_port_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_addr  (req0_addr),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_addr  (req1_addr),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .wb_src     (wb_src),
        .conflict   (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [15:0] d0;
        logic [2:0]  a0;
        logic        v1;
        logic [15:0] d1;
        logic [2:0]  a1;
        logic        wr;
        logic        er0;   // req0_ready before the edge
        logic        er1;   // req1_ready before the edge
        logic        ewv;   // wb_valid after the edge
        logic [15:0] ewd;
        logic [2:0]  ewa;
        logic        esrc;
        logic        econf;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mkv(
        input logic rst_i, input logic v0, input logic [15:0] d0, input logic [2:0] a0,
        input logic v1, input logic [15:0] d1, input logic [2:0] a1, input logic wr,
        input logic er0, input logic er1, input logic ewv, input logic [15:0] ewd,
        input logic [2:0] ewa, input logic esrc, input logic econf);
        vec_t r;
        r.rst = rst_i; r.v0 = v0; r.d0 = d0; r.a0 = a0;
        r.v1 = v1; r.d1 = d1; r.a1 = a1; r.wr = wr;
        r.er0 = er0; r.er1 = er1; r.ewv = ewv; r.ewd = ewd;
        r.ewa = ewa; r.esrc = esrc; r.econf = econf;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst        = t.rst;
        req0_valid = t.v0;
        req0_data  = t.d0;
        req0_addr  = t.a0;
        req1_valid = t.v1;
        req1_data  = t.d1;
        req1_addr  = t.a1;
        wb_ready   = t.wr;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; req0_valid = 1'b0; req0_data = 16'h0; req0_addr = 3'd0;
        req1_valid = 1'b0; req1_data = 16'h0; req1_addr = 3'd0; wb_ready = 1'b0;

        //               rst   v0    d0        a0    v1    d1        a1    wr    r0rdy r1rdy wbv   wbd       wba   src   conf
        // reset
        vecs[0]  = mkv(1'b1, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        // single req0 beat, then drain without refill
        vecs[1]  = mkv(1'b0, 1'b1, 16'h1234, 3'd3, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 3'd3, 1'b0, 1'b0);
        vecs[2]  = mkv(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 3'd3, 1'b0, 1'b0);
        // reset, then both valid: alternate 0,1,0,1 with conflict
        vecs[3]  = mkv(1'b1, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        vecs[4]  = mkv(1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b0, 1'b1);
        vecs[5]  = mkv(1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b1);
        vecs[6]  = mkv(1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b0, 1'b1);
        vecs[7]  = mkv(1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b1);
        // stall 3 cycles: readies 0, payload stable, no conflict (cannot load)
        vecs[8]  = mkv(1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b0);
        vecs[9]  = mkv(1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b0);
        vecs[10] = mkv(1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b0);
        // stall clears: req1 was last served, so req0 wins
        vecs[11] = mkv(1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b0, 1'b1);
        // req1 streaming alone, last index is register 0
        vecs[12] = mkv(1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h0001, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0001, 3'd5, 1'b1, 1'b0);
        vecs[13] = mkv(1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h0002, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 3'd6, 1'b1, 1'b0);
        vecs[14] = mkv(1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h0003, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 3'd7, 1'b1, 1'b0);
        vecs[15] = mkv(1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h0004, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0004, 3'd0, 1'b1, 1'b0);
        // load 0xBEEF, stall, reset mid-stall, then contested cycle grants req0
        vecs[16] = mkv(1'b0, 1'b1, 16'hBEEF, 3'd4, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hBEEF, 3'd4, 1'b0, 1'b0);
        vecs[17] = mkv(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 3'd4, 1'b0, 1'b0);
        vecs[18] = mkv(1'b1, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0);
        vecs[19] = mkv(1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b1, 16'h5555, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b0, 1'b1);
        vecs[20] = mkv(1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hAAAA, 3'd1, 1'b0, 1'b0);
        // empty stage loads even with wb_ready low; then stall, then resume
        vecs[21] = mkv(1'b0, 1'b0, 16'h0000, 3'd0, 1'b1, 16'h7777, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7777, 3'd6, 1'b1, 1'b0);
        vecs[22] = mkv(1'b0, 1'b1, 16'h1111, 3'd1, 1'b1, 16'h7777, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7777, 3'd6, 1'b1, 1'b0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk("req0_ready", i, {31'd0, req0_ready}, {31'd0, vecs[i].er0});
            chk("req1_ready", i, {31'd0, req1_ready}, {31'd0, vecs[i].er1});
            @(posedge clk);
            #1;
            chk("wb_valid", i, {31'd0, wb_valid}, {31'd0, vecs[i].ewv});
            chk("wb_data",  i, {16'd0, wb_data},  {16'd0, vecs[i].ewd});
            chk("wb_addr",  i, {29'd0, wb_addr},  {29'd0, vecs[i].ewa});
            chk("wb_src",   i, {31'd0, wb_src},   {31'd0, vecs[i].esrc});
            chk("conflict", i, {31'd0, conflict}, {31'd0, vecs[i].econf});
        end

        // Fairness: stage holds 0x7777 from req1 (last=1); both valid with
        // wb_ready high must give 0,1,0,1,... and never drop wb_valid.
        begin
            logic exp_src;
            exp_src = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                rst = 1'b0; req0_valid = 1'b1; req0_data = 16'h1111; req0_addr = 3'd1;
                req1_valid = 1'b1; req1_data = 16'h2222; req1_addr = 3'd2; wb_ready = 1'b1;
                #2;
                chk("fair_onehot", 100 + k, {31'd0, req0_ready & req1_ready}, 32'd0);
                @(posedge clk);
                #1;
                chk("fair_valid", 100 + k, {31'd0, wb_valid}, 32'd1);
                chk("fair_src",   100 + k, {31'd0, wb_src},   {31'd0, exp_src});
                chk("fair_data",  100 + k, {16'd0, wb_data},  exp_src ? 32'h2222 : 32'h1111);
                exp_src = ~exp_src;
            end
        end

        // Stall with only req0 waiting; release after two cycles and wait,
        // bounded, for req0_ready.
        begin
            int  found_at;
            found_at = -1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                req1_valid = 1'b0;
                req0_valid = 1'b1;
                req0_data  = 16'h3C3C;
                req0_addr  = 3'd5;
                wb_ready   = (c >= 2) ? 1'b1 : 1'b0;
                #2;
                if (req0_ready && found_at < 0) found_at = c;
                @(posedge clk);
                if (found_at >= 0) break;
            end
            chk("stall_release_cycle", 200, found_at, 32'd2);
            #1;
            chk("stall_release_data", 201, {16'd0, wb_data}, 32'h3C3C);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single 16-bit register-file write port between two requesters: ALU result (req 0) and load/immediate path (req 1).
- Owns the 2-to-1 data select that feeds the port; each cycle it decides which source drives it.
- Round-robin arbitration; valid/ready handshake on both inputs and the output.
- Registered output stage, 1-cycle latency, sustains one transfer per cycle.

Parameters:
- DATA_W, 16, width of the write data.
- ADDR_W, 3, width of the destination register index.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req0_data  in  DATA_W  requester 0 write data.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req1_valid  in  1  requester 1 has a write pending.
- req1_ready  out  1  requester 1 transfer accepted this cycle.
- req1_data  in  DATA_W  requester 1 write data.
- req1_addr  in  ADDR_W  requester 1 destination register.
- wb_valid  out  1  registered write presented to the register file.
- wb_ready  in  1  register file accepts the write this cycle.
- wb_data  out  DATA_W  registered write data.
- wb_addr  out  ADDR_W  registered destination register.
- wb_src  out  1  source of the current wb beat (0 = req0, 1 = req1).
- conflict  out  1  registered; 1 for one cycle after a beat where both requesters were valid and a load occurred.

Behaviour:
- Reset (rst=1 at clk edge):
  - wb_valid=0, wb_data=0, wb_addr=0, wb_src=0, conflict=0.
  - Last-grant pointer last=1, so req0 wins the first contested cycle.
  - rst overrides all other activity in the same cycle. A beat in flight is dropped and not replayed.
  - reqX_ready is combinational and is 0 while rst=1.
- Definitions:
  - can_load = !wb_valid || wb_ready (output register empty or draining this cycle).
  - Grant is combinational:
    - Only req0_valid: grant=0.
    - Only req1_valid: grant=1.
    - Both valid: grant = !last.
    - Neither valid: no grant.
- Ready rules:
  - reqX_ready = can_load && granted(X) && !rst.
  - At most one ready is high per cycle.
  - reqX_ready is never high while reqX_valid=0.
- Transfer: a transfer on requester X occurs when reqX_valid && reqX_ready. On the next edge:
  - wb_data <= reqX_data and wb_addr <= reqX_addr.
  - wb_src <= X, wb_valid <= 1, last <= X.
- Output drain:
  - If wb_valid && wb_ready and no input transfer occurs, wb_valid <= 0 next edge.
  - wb_data, wb_addr and wb_src hold their values.
- Back-to-back: when wb_ready=1 and a requester is valid, a new beat loads in the same cycle the old one drains. wb_valid stays 1 and throughput is 1 beat/cycle.
- Stall: when wb_valid=1 and wb_ready=0:
  - wb_data, wb_addr and wb_src hold stable; both readies are 0.
  - last is not updated; arbitration resumes unchanged when the stall clears.
- Fairness: with both requesters continuously valid and wb_ready=1, grants strictly alternate 0,1,0,1…
  - Neither requester waits more than one transfer while the other is served.
- Requester behaviour: a requester may drop valid without a transfer. Arbitration follows current valids only; no request latching inside the block.
- Input stability:
  - Requesters must hold data and addr stable while valid && !ready.
  - Violations are not detected.
- conflict: conflict <= (req0_valid && req1_valid && can_load) each edge; 0 under reset.
- Address value: no special-casing of wb_addr==0 (register 0). It is forwarded like any other index.
- States:
  - EMPTY: wb_valid=0.
  - FULL: wb_valid=1.
  - EMPTY→FULL on a transfer.
  - FULL→EMPTY on wb_ready with no transfer.
  - FULL→FULL on a stall, or on drain+transfer.

Test Plan:
- Reset, then req0_valid=1, data=0x1234, addr=3, wb_ready=1 → req0_ready=1 in the same cycle. Next cycle: wb_valid=1, wb_data=0x1234, wb_addr=3, wb_src=0.
- Both valid from reset (req0 0xAAAA/addr1, req1 0x5555/addr2), wb_ready=1 held for 4 cycles → wb_src sequence 0,1,0,1; conflict=1 on each beat; wb_valid never drops.
- Output stall: load a beat, then wb_ready=0 for 3 cycles with both valid → both readies 0, wb_data stable. When wb_ready returns to 1, the next grant goes to the requester not last served.
- Single requester streaming: req1 only, data 0x0001..0x0004, wb_ready=1 → four consecutive beats, wb_src=1 throughout, req0_ready never 1, conflict=0.
- Reset mid-operation: wb_valid=1 stalled with 0xBEEF, assert rst for 1 cycle → next cycle wb_valid=0, wb_data=0, readies 0 during rst. A subsequent contested cycle grants req0.
- Drain without refill: one beat loaded, then both valids 0 with wb_ready=1 → wb_valid=0 the following cycle; wb_data retains its last value.
